// File: rtl/bg_fetch_pkg.sv
// Shared types and constants for the background scanline fetcher.
package bg_fetch_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned COL_W    = 5;
  localparam int unsigned LINE_W   = 16;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned BSM_W    = 19;
  localparam int unsigned PMBA_W   = 5;
  localparam int unsigned LAST_COL = 31;

  localparam logic [ADDR_W-1:0] NTBL_COLORS_OFFSET = 12'd960;

  // Tile byte field positions
  localparam int unsigned TILE_SEL_BIT   = 7;
  localparam int unsigned TILE_HFLIP_BIT = 6;
  localparam int unsigned TILE_VFLIP_BIT = 5;
  localparam int unsigned TILE_PMBA_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_COLOR,
    RD_TILE,
    RD_PAT0,
    RD_PAT1,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [LINE_W-1:0]  line;
  } bsm_entry_t;

endpackage

// File: rtl/pattern_hflipper_m.sv
// Mirrors a row of eight 2-bit pixels; the bits inside each pixel keep their order.
module pattern_hflipper_m (
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  logic [15:0] rev;

  always_comb begin
    rev = '0;
    for (int i = 0; i < 8; i++) begin
      rev[2*i +: 2] = din[2*(7-i) +: 2];
    end
  end

  assign dout = en ? rev : din;

endmodule

// File: rtl/background_line_fetcher.sv
// Serial VRAM fetcher: colour byte, then tile + two pattern bytes per column,
// producing one BSM entry every 3 cycles.
module background_line_fetcher
  import bg_fetch_pkg::*;
#(
  parameter logic [11:0] NTBL_BASE = 12'h400,
  parameter logic [11:0] PMB_BASE  = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        line_y,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_rdata,
  output logic              bsm_we,
  output logic [COL_W-1:0]  bsm_col,
  output logic [BSM_W-1:0]  bsm_data,
  output logic              busy,
  output logic              done
);

  state_t             state, state_next;
  logic [COL_W-1:0]   col;
  logic [7:0]         ly_q;
  logic [7:0]         tile_q;
  logic [7:0]         pat0_q;
  logic [5:0]         color_q;

  logic               rd_c;
  logic [ADDR_W-1:0]  addr_c;
  logic               wr_c;
  logic [7:0]         tile_src;
  logic [2:0]         vy;
  logic [LINE_W-1:0]  line_flip;
  bsm_entry_t         entry;

  // Pattern address uses the live tile byte in RD_PAT0 and the latched copy afterwards
  assign tile_src = (state == RD_PAT0) ? vram_rdata : tile_q;
  assign vy       = tile_src[TILE_VFLIP_BIT] ? 3'(3'd7 - ly_q[2:0]) : ly_q[2:0];

  pattern_hflipper_m u_hflip (
    .en   (tile_q[TILE_HFLIP_BIT]),
    .din  ({pat0_q, vram_rdata}),
    .dout (line_flip)
  );

  assign entry.color = tile_q[TILE_SEL_BIT] ? color_q[5:3] : color_q[2:0];
  assign entry.line  = line_flip;

  always_comb begin
    state_next = state;
    rd_c       = 1'b0;
    addr_c     = '0;
    wr_c       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RD_COLOR;
      end
      RD_COLOR: begin
        rd_c       = 1'b1;
        addr_c     = NTBL_BASE + NTBL_COLORS_OFFSET;
        state_next = RD_TILE;
      end
      RD_TILE: begin
        rd_c       = 1'b1;
        addr_c     = NTBL_BASE + 12'({ly_q[7:3], col});
        wr_c       = (col != '0);
        state_next = RD_PAT0;
      end
      RD_PAT0: begin
        rd_c       = 1'b1;
        addr_c     = PMB_BASE + 12'({tile_src[TILE_PMBA_LSB +: PMBA_W], vy, 1'b0});
        state_next = RD_PAT1;
      end
      RD_PAT1: begin
        rd_c       = 1'b1;
        addr_c     = PMB_BASE + 12'({tile_src[TILE_PMBA_LSB +: PMBA_W], vy, 1'b1});
        state_next = (col == COL_W'(LAST_COL)) ? FLUSH : RD_TILE;
      end
      FLUSH: begin
        wr_c       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign vram_rd   = rd_c;
  assign vram_addr = addr_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      col      <= '0;
      ly_q     <= '0;
      tile_q   <= '0;
      pat0_q   <= '0;
      color_q  <= '0;
      bsm_we   <= 1'b0;
      bsm_col  <= '0;
      bsm_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != IDLE);
      bsm_we <= wr_c;
      done   <= (state == FLUSH);
      if (state == IDLE && start) begin
        ly_q <= line_y;
        col  <= '0;
      end
      if (state == RD_TILE && col == '0) color_q <= vram_rdata[5:0];
      if (state == RD_PAT0) tile_q <= vram_rdata;
      if (state == RD_PAT1) begin
        pat0_q <= vram_rdata;
        if (col != COL_W'(LAST_COL)) col <= col + COL_W'(1);
      end
      // Byte 1 of the previous column arrives in the cycle after RD_PAT1
      if (wr_c) begin
        bsm_col  <= (state == FLUSH) ? col : col - COL_W'(1);
        bsm_data <= entry;
      end
    end
  end

endmodule

// File: tb/tb_background_line_fetcher.sv
// Directed bench with a VRAM model and scoreboards for read addresses and BSM writes.
module tb_background_line_fetcher;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  line_y;
  logic        vram_rd;
  logic [11:0] vram_addr;
  logic [7:0]  vram_rdata;
  logic        bsm_we;
  logic [4:0]  bsm_col;
  logic [18:0] bsm_data;
  logic        busy;
  logic        done;

  background_line_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .line_y     (line_y),
    .vram_rd    (vram_rd),
    .vram_addr  (vram_addr),
    .vram_rdata (vram_rdata),
    .bsm_we     (bsm_we),
    .bsm_col    (bsm_col),
    .bsm_data   (bsm_data),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int          cyc;
    logic [11:0] addr;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [4:0]  col;
    logic [18:0] data;
  } wr_exp_t;

  logic [7:0]  mem [0:4095];
  rd_exp_t     exp_rd[$];
  wr_exp_t     exp_wr[$];
  int          cyc;
  int          checks;
  int          failures;
  int          wr_cnt;
  int          done_cnt;
  int          done_cyc;
  logic [18:0] col0_data;
  int          t0;
  int          t1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // VRAM: data valid the cycle after the read strobe
  always @(posedge clk) vram_rdata <= (vram_rd === 1'b1) ? mem[vram_addr] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clear_counts();
    wr_cnt   = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic push_fetch(input logic [7:0] y, input int ts);
    logic [7:0]  cb, t, p0, p1;
    logic [2:0]  vy;
    logic [11:0] ta, pa;
    logic [15:0] ln, lf;
    logic [2:0]  colr;
    cb = mem[12'h7C0];
    exp_rd.push_back('{ts + 1, 12'h7C0});
    for (int c = 0; c < 32; c++) begin
      ta = 12'h400 + 12'({y[7:3], 5'(c)});
      t  = mem[ta];
      vy = t[5] ? 3'(3'd7 - y[2:0]) : y[2:0];
      pa = 12'({t[4:0], vy, 1'b0});
      exp_rd.push_back('{ts + 2 + 3*c, ta});
      exp_rd.push_back('{ts + 3 + 3*c, pa});
      exp_rd.push_back('{ts + 4 + 3*c, pa + 12'd1});
      p0 = mem[pa];
      p1 = mem[pa + 12'd1];
      ln = {p0, p1};
      for (int i = 0; i < 8; i++) lf[2*i +: 2] = ln[2*(7-i) +: 2];
      if (!t[6]) lf = ln;
      colr = t[7] ? cb[5:3] : cb[2:0];
      exp_wr.push_back('{ts + 6 + 3*c, 5'(c), {colr, lf}});
    end
  endtask

  task automatic run_fetch(input logic [7:0] y, output int ts);
    clear_counts();
    ts = cyc;
    push_fetch(y, ts);
    start  = 1'b1;
    line_y = y;
    tick();
    start  = 1'b0;
  endtask

  // Scoreboard side: compare every read strobe and BSM write as it appears
  always @(negedge clk) begin
    if (vram_rd === 1'b1) begin
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 32'(vram_addr), 32'hFFFF_FFFF);
      end else begin
        rd_exp_t e;
        e = exp_rd.pop_front();
        chk("rd_addr", 32'(vram_addr), 32'(e.addr));
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (bsm_we === 1'b1) begin
      wr_cnt++;
      if (bsm_col === 5'd0) col0_data = bsm_data;
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 32'(bsm_col), 32'hFFFF_FFFF);
      end else begin
        wr_exp_t w;
        w = exp_wr.pop_front();
        chk("wr_col", 32'(bsm_col), 32'(w.col));
        chk("wr_data", 32'(bsm_data), 32'(w.data));
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    col0_data = '0;
    clear_counts();
    rst    = 1'b0;
    start  = 1'b1;
    line_y = 8'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h7C0] = 8'b0011_0011;
    for (int c = 0; c < 32; c++) begin
      mem[12'h400 + 12'(c)] = 8'h01;
      mem[12'h420 + 12'(c)] = 8'hE2;
    end
    mem[12'h010] = 8'hCC;
    mem[12'h011] = 8'hCC;
    mem[12'h024] = 8'h1B;
    mem[12'h025] = 8'h00;

    // Reset held with start asserted
    repeat (3) begin
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(bsm_we), 32'd0);
      chk("rst_rd", 32'(vram_rd), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(vram_addr), 32'd0);
      chk("rst_col", 32'(bsm_col), 32'd0);
      chk("rst_data", 32'(bsm_data), 32'd0);
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rd", 32'(vram_rd), 32'd0);

    // Basic line, row 0
    run_fetch(8'd0, t0);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_until(t0 + 100);
    chk("basic_wr_cnt", 32'(wr_cnt), 32'd32);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_done_cyc", 32'(done_cyc), 32'(t0 + 99));
    chk("basic_col0", 32'(col0_data), 32'({3'b011, 16'hCCCC}));
    chk("basic_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("basic_busy_end", 32'(busy), 32'd0);

    // Colour select, vflip and hflip on row 1
    run_fetch(8'd13, t0);
    wait_until(t0 + 100);
    chk("flip_wr_cnt", 32'(wr_cnt), 32'd32);
    chk("flip_col0", 32'(col0_data), 32'({3'b110, 16'h00E4}));
    chk("flip_done_cyc", 32'(done_cyc), 32'(t0 + 99));

    // Start while busy is dropped
    run_fetch(8'd0, t0);
    wait_until(t0 + 50);
    start  = 1'b1;
    line_y = 8'd13;
    tick();
    start  = 1'b0;
    wait_until(t0 + 100);
    chk("busy_start_wr", 32'(wr_cnt), 32'd32);
    chk("busy_start_done", 32'(done_cnt), 32'd1);
    chk("busy_start_rd_left", 32'(exp_rd.size()), 32'd0);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Reset mid-fetch at cycle 40
    run_fetch(8'd13, t0);
    wait_until(t0 + 40);
    rst = 1'b0;
    tick();
    exp_rd.delete();
    exp_wr.delete();
    chk("abort_we", 32'(bsm_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd", 32'(vram_rd), 32'd0);
    rst = 1'b1;
    wait_until(t0 + 110);
    chk("abort_done", 32'(done_cnt), 32'd0);
    chk("abort_wr_cnt", 32'(wr_cnt), 32'd12);
    run_fetch(8'd0, t0);
    wait_until(t0 + 100);
    chk("after_abort_wr", 32'(wr_cnt), 32'd32);
    chk("after_abort_done_cyc", 32'(done_cyc), 32'(t0 + 99));

    // Back-to-back: second start in cycle 99
    run_fetch(8'd0, t0);
    wait_until(t0 + 99);
    chk("b2b_busy99", 32'(busy), 32'd0);
    chk("b2b_done99", 32'(done), 32'd1);
    t1 = cyc;
    push_fetch(8'd13, t1);
    start  = 1'b1;
    line_y = 8'd13;
    tick();
    start  = 1'b0;
    chk("b2b_busy100", 32'(busy), 32'd1);
    wait_until(t1 + 100);
    chk("b2b_wr_cnt", 32'(wr_cnt), 32'd64);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_done_cyc", 32'(done_cyc), 32'(t1 + 99));
    chk("b2b_col0", 32'(col0_data), 32'({3'b110, 16'h00E4}));
    chk("b2b_wr_left", 32'(exp_wr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
